qsn_shift_pipe_85b: RTL

QSN_SHIFT_PIPE_85B -- requirements
Module: qsn_shift_pipe_85b

---
 rtl/qsn_shift_pipe_85b.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/qsn_shift_pipe_85b.sv
// Two-stage QSN cyclic-shift pipeline for Z=85 QC-LDPC message blocks.
// S1 holds the messages plus precomputed QSN controls, S2 holds the rotated result.

module qsn_shift_net #(
  parameter int Z          = 85,
  parameter int SW         = 7,
  parameter bit TOWARD_LOW = 1'b1
) (
  input  logic [Z-1:0]  din,
  input  logic [SW-1:0] sel,
  output logic [Z-1:0]  dout
);

  // Log-depth barrel shifter with zero fill; TOWARD_LOW moves bit j+sel down to j.
  logic [Z-1:0] stage [0:SW];

  assign stage[0] = din;

  for (genvar k = 0; k < SW; k++) begin : g_stage
    localparam int AMT = 1 << k;
    if (TOWARD_LOW) begin : g_low
      assign stage[k+1] = sel[k] ? (stage[k] >> AMT) : stage[k];
    end else begin : g_high
      assign stage[k+1] = sel[k] ? (stage[k] << AMT) : stage[k];
    end
  end

  assign dout = stage[SW];

endmodule

module qsn_top_85b #(
  parameter int Z     = 85,
  parameter int MSG_W = 4
) (
  input  logic [MSG_W-1:0][Z-1:0] msg,
  input  logic [6:0]              left_sel,
  input  logic [6:0]              right_sel,
  input  logic [Z-2:0]            merge_sel,
  output logic [MSG_W-1:0][Z-1:0] msg_out
);

  logic [Z-1:0] left_net  [MSG_W];
  logic [Z-1:0] right_net [MSG_W];
  logic [Z-1:0] merge_full;

  // The top bit always wraps in from the right network, so its select is fixed to 0.
  assign merge_full = {1'b0, merge_sel};

  for (genvar p = 0; p < MSG_W; p++) begin : g_plane
    qsn_shift_net #(.Z(Z), .SW(7), .TOWARD_LOW(1'b1)) u_left (
      .din  (msg[p]),
      .sel  (left_sel),
      .dout (left_net[p])
    );

    qsn_shift_net #(.Z(Z), .SW(7), .TOWARD_LOW(1'b0)) u_right (
      .din  (msg[p]),
      .sel  (right_sel),
      .dout (right_net[p])
    );

    assign msg_out[p] = (merge_full & left_net[p]) | (~merge_full & right_net[p]);
  end

endmodule

module qsn_shift_pipe_85b #(
  parameter int Z     = 85,
  parameter int MSG_W = 4
) (
  input  logic          sys_clk,
  input  logic          rstn,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    shift_in,
  input  logic [Z-1:0]  msg_in_bit0,
  input  logic [Z-1:0]  msg_in_bit1,
  input  logic [Z-1:0]  msg_in_bit2,
  input  logic [Z-1:0]  msg_in_bit3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [Z-1:0]  msg_out_bit0,
  output logic [Z-1:0]  msg_out_bit1,
  output logic [Z-1:0]  msg_out_bit2,
  output logic [Z-1:0]  msg_out_bit3,
  output logic          shift_err,
  output logic [15:0]   blk_cnt
);

  logic [MSG_W-1:0][Z-1:0] msg_in_all;
  logic [MSG_W-1:0][Z-1:0] qsn_out;
  logic [MSG_W-1:0][Z-1:0] s1_msg;
  logic [MSG_W-1:0][Z-1:0] s2_msg;
  logic [6:0]              s_eff;
  logic                    shift_oob;
  logic [6:0]              right_next;
  logic [Z-2:0]            merge_next;
  logic [6:0]              s1_left_sel;
  logic [6:0]              s1_right_sel;
  logic [Z-2:0]            s1_merge_sel;
  logic                    s1_valid;
  logic                    s2_valid;
  logic                    s1_adv;
  logic                    s2_adv;
  logic                    accept;

  assign msg_in_all = {msg_in_bit3, msg_in_bit2, msg_in_bit1, msg_in_bit0};

  // A 7-bit shift never exceeds 2*Z-1, so one conditional subtract fully reduces it.
  assign shift_oob  = (shift_in >= 7'(Z));
  assign s_eff      = shift_oob ? (shift_in - 7'(Z)) : shift_in;
  assign right_next = (s_eff == 7'd0) ? 7'd0 : (7'(Z) - s_eff);

  always_comb begin
    merge_next = '0;
    for (int j = 0; j < Z - 1; j++) begin
      merge_next[j] = (j < (Z - int'(s_eff)));
    end
  end

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = s2_adv || !s1_valid;
  assign in_ready = s1_adv;
  assign accept   = in_valid && s1_adv;

  // Stage 1: capture messages and the QSN controls derived from the reduced shift.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid     <= 1'b0;
      s1_msg       <= '0;
      s1_left_sel  <= '0;
      s1_right_sel <= '0;
      s1_merge_sel <= '0;
    end else if (s1_adv) begin
      s1_valid     <= in_valid;
      s1_msg       <= msg_in_all;
      s1_left_sel  <= s_eff;
      s1_right_sel <= right_next;
      s1_merge_sel <= merge_next;
    end
  end

  qsn_top_85b #(.Z(Z), .MSG_W(MSG_W)) u_qsn (
    .msg       (s1_msg),
    .left_sel  (s1_left_sel),
    .right_sel (s1_right_sel),
    .merge_sel (s1_merge_sel),
    .msg_out   (qsn_out)
  );

  // Stage 2: register the rotated block; it holds while the consumer stalls.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s2_valid <= 1'b0;
      s2_msg   <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      s2_msg   <= qsn_out;
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      shift_err <= 1'b0;
      blk_cnt   <= '0;
    end else begin
      if (accept && shift_oob) begin
        shift_err <= 1'b1;
      end
      if (s2_valid && out_ready) begin
        blk_cnt <= blk_cnt + 16'd1;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign msg_out_bit0 = s2_msg[0];
  assign msg_out_bit1 = s2_msg[1];
  assign msg_out_bit2 = s2_msg[2];
  assign msg_out_bit3 = s2_msg[3];

endmodule
